// File: rtl/i2s_tx.sv
// I2S serializer: stereo pairs go out MSB-first in 32-bit slots, SCLK/LRCLK divided from Clk; optional I2S_TX_UNDERRUN_CNT_EN.
// One-pair holding register (in_ready low while full); a frame load with it empty repeats the last pair.
module i2s_tx #(
   parameter int SCLK_DIV = 8,
   parameter int SAMPLE_W = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [SAMPLE_W-1:0] in_left,
   input  logic [SAMPLE_W-1:0] in_right,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                sclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                frame_tick,
   output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]         underrun_count
`endif
);

   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   logic [DIV_W-1:0]    r_div_cnt;
   logic                r_sclk;
   logic                r_lrclk;
   logic                r_sdata;
   logic [5:0]          r_bit_cnt;
   logic [SAMPLE_W-1:0] r_left;
   logic [SAMPLE_W-1:0] r_right;
   logic [SAMPLE_W-1:0] r_hold_l;
   logic [SAMPLE_W-1:0] r_hold_r;
   logic                r_hold_full;

   logic                w_tick;
   logic                w_fall;
   logic                w_load;
   logic                w_accept;
   logic                w_bit;
   logic [5:0]          w_nxt;
   logic [SAMPLE_W-1:0] w_sample;

   assign w_tick   = (r_div_cnt == DIV_W'(SCLK_DIV - 1));
   assign w_fall   = w_tick & r_sclk;
   assign w_nxt    = r_bit_cnt + 6'd1;
   assign w_load   = w_fall & (w_nxt == 6'd0);
   assign w_accept = in_valid & ~r_hold_full;
   assign w_sample = w_nxt[5] ? r_right : r_left;

   // Slot position p carries sample bit SAMPLE_W-p; p==0 is the I2S delay bit, p>SAMPLE_W is padding.
   always_comb begin
      w_bit = 1'b0;
      for (int i = 0; i < SAMPLE_W; i++) begin
         if (w_nxt[4:0] == 5'(SAMPLE_W - i)) w_bit = w_sample[i];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_div_cnt   <= '0;
         r_sclk      <= 1'b0;
         r_lrclk     <= 1'b0;
         r_sdata     <= 1'b0;
         r_bit_cnt   <= '0;
         r_left      <= '0;
         r_right     <= '0;
         r_hold_l    <= '0;
         r_hold_r    <= '0;
         r_hold_full <= 1'b0;
      end else begin
         if (w_tick) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end
         if (w_fall) begin
            r_bit_cnt <= w_nxt;
            r_lrclk   <= w_nxt[5];
            r_sdata   <= w_bit;
         end
         if (w_load && r_hold_full) begin
            r_left      <= r_hold_l;
            r_right     <= r_hold_r;
            r_hold_full <= 1'b0;
         end
         // Accept only happens when empty, so it never races the load that drains holding.
         if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_l    <= in_left;
            r_hold_r    <= in_right;
         end
      end
   end

   assign in_ready   = ~r_hold_full;
   assign sclk       = r_sclk;
   assign lrclk      = r_lrclk;
   assign sdata      = r_sdata;
   assign frame_tick = w_load & ~Reset;
   assign underrun   = w_load & ~r_hold_full & ~Reset;

`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] r_urun_cnt;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_urun_cnt <= '0;
      end else if (underrun && (r_urun_cnt != 16'hFFFF)) begin
         r_urun_cnt <= r_urun_cnt + 16'd1;
      end
   end

   assign underrun_count = r_urun_cnt;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx: a cycle-count model predicts SCLK/LRCLK/SDATA and the handshake.
module tb_i2s_tx;
   localparam int D  = 8;
   localparam int SW = 16;
   localparam int F  = 128 * D;

   logic          clk = 1'b0;
   logic          Reset;
   logic [SW-1:0] in_left, in_right;
   logic          in_valid, in_ready;
   logic          sclk, lrclk, sdata, frame_tick, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0]   ucnt;
`endif

   always #5 clk = ~clk;

   i2s_tx #(.SCLK_DIV(D), .SAMPLE_W(SW)) dut (
      .Clk(clk), .Reset(Reset), .in_left(in_left), .in_right(in_right),
      .in_valid(in_valid), .in_ready(in_ready), .sclk(sclk), .lrclk(lrclk),
      .sdata(sdata), .frame_tick(frame_tick), .underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
      , .underrun_count(ucnt)
`endif
   );

   int n_chk = 0;
   int n_pass = 0;
   int cur_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cur_cyc, got, exp);
      else
         n_pass++;
   endtask

   // Model: edges since reset, the pair being sent, and the pending (holding) pair.
   int            n;
   logic [SW-1:0] cur_l, cur_r, pend_l, pend_r;
   bit            pend_v, last_acc, first_done, rst_done, want, rdy_old, load_now;
   int            ucnt_m;

   function automatic logic exp_sdata(int nn);
      int            b;
      int            p;
      logic [SW-1:0] s;
      b = (nn / (2 * D)) % 64;
      p = b % 32;
      s = (b >= 32) ? cur_r : cur_l;
      if (p >= 1 && p <= SW) return s[SW-p];
      return 1'b0;
   endfunction

   initial begin
      Reset = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
      n = 0; cur_l = '0; cur_r = '0; pend_l = '0; pend_r = '0;
      pend_v = 0; last_acc = 0; first_done = 0; rst_done = 0; ucnt_m = 0;

      for (int cyc = 0; cyc < 17 * F; cyc++) begin
         @(negedge clk);
         cur_cyc = cyc;
         Reset = (cyc < 3);
         if (cyc >= 14 * F && !rst_done && (n % F) == 41 * D) begin
            Reset = 1'b1;
            rst_done = 1;
         end

         // Producer keeps an offer stable until it is taken.
         if (!(in_valid && !last_acc)) begin
            if (cyc < 5)           want = 0;
            else if (cyc < 4 * F)  want = 1;
            else if (cyc < 7 * F)  want = 0;
            else if (cyc < 9 * F)  want = !pend_v && ((n + 1) % F == 0);
            else                   want = ($urandom_range(0, 299) == 0);
            in_valid = want;
            if (want && !first_done) begin
               in_left = 16'hA5C3; in_right = 16'h0F0F; first_done = 1;
            end else if (want) begin
               in_left = SW'($urandom); in_right = SW'($urandom);
            end
         end

         #1;
         if (cyc >= 1) begin
            load_now = !Reset && ((n + 1) % F == 0);
            chk("sclk",       32'(sclk),       32'((n / D) % 2));
            chk("lrclk",      32'(lrclk),      32'(((n / (2 * D)) % 64) / 32));
            chk("sdata",      32'(sdata),      32'(exp_sdata(n)));
            chk("frame_tick", 32'(frame_tick), 32'(load_now));
            chk("underrun",   32'(underrun),   32'(load_now && !pend_v));
            chk("in_ready",   32'(in_ready),   32'(!pend_v));
`ifdef I2S_TX_UNDERRUN_CNT_EN
            chk("underrun_count", 32'(ucnt), 32'(ucnt_m));
`endif
         end

         // Effect of the coming clock edge.
         if (Reset) begin
            n = 0; pend_v = 0; cur_l = '0; cur_r = '0; last_acc = 0; ucnt_m = 0;
         end else begin
            rdy_old = !pend_v;
            n++;
            if (n % F == 0) begin
               if (pend_v) begin
                  cur_l = pend_l; cur_r = pend_r; pend_v = 0;
               end else if (ucnt_m < 65535) begin
                  ucnt_m++;
               end
            end
            last_acc = in_valid && rdy_old;
            if (last_acc) begin
               pend_l = in_left; pend_r = in_right; pend_v = 1;
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
